mos6502s_interrupt_sequencer: RTL and testbench
===============================================

MOS6502S_INTERRUPT_SEQUENCER -- requirements
Module: mos6502s_interrupt_sequencer

Interface
REQ-001 SHALL have port clk, input, 1: clock; all state changes on rising edge.
REQ-002 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-003 SHALL have port nmi_n, input, 1: non-maskable interrupt, active-low, edge-sensitive.
REQ-004 SHALL have port irq_n, input, 1: maskable interrupt, active-low, level-sensitive.
REQ-005 SHALL have port i_flag, input, 1: CPU interrupt-disable flag.
REQ-006 SHALL have port insn_done, input, 1: instruction-boundary pulse from the CPU core.
REQ-007 SHALL have ports pc_in (input, 16: current PC), sp_in (input, 8: current stack pointer) and p_in (input, 8: status register).
REQ-008 SHALL have port data_in, input, 8: read data, valid in the same cycle addr is driven.
REQ-009 SHALL have ports addr (output, 16: memory address), data_out (output, 8: write data) and we (output, 1: write strobe).
REQ-010 SHALL have ports pc_load (output, 1) and pc_addr (output, 16): drive program-counter load and load value; pc inc is held 0 by the integrator during pc_load.
REQ-011 SHALL have ports sp_dec (output, 1: decrement SP this cycle), set_i (output, 1: set I flag) and busy (output, 1: sequence active; core stalls).

Function
REQ-012 SHALL implement states RST_LO, RST_HI, IDLE, PUSH_H, PUSH_L, PUSH_P, VEC_LO, VEC_HI, LOAD; one cycle per state except IDLE.
REQ-013 SHALL register nmi_n each cycle; a 1->0 transition between consecutive samples sets nmi_pend; a constant low level sets it only once.
REQ-014 In IDLE with insn_done=1: if nmi_pend=1, SHALL go to PUSH_H with kind=NMI; else if irq_n=0 and i_flag=0, SHALL go to PUSH_H with kind=IRQ; else SHALL stay in IDLE.
REQ-015 SHALL ignore IRQ without insn_done, and SHALL ignore IRQ while i_flag=1; IRQ is not latched.
REQ-016 SHALL clear nmi_pend on entry to PUSH_H when kind=NMI; an edge in the same cycle as that clear SHALL win (set), so no edge is lost.
REQ-017 PUSH_H SHALL drive addr={8'h01,sp_in}, data_out=pc_in[15:8], we=1, sp_dec=1; sp_in is expected decremented by the next cycle.
REQ-018 PUSH_L SHALL do the same with data_out=pc_in[7:0].
REQ-019 PUSH_P SHALL do the same with data_out=p_in, bit4 (B) forced 0 and bit5 forced 1.
REQ-020 If kind=IRQ and nmi_pend=1 in any PUSH state, kind SHALL switch to NMI (hijack) and nmi_pend SHALL clear.
REQ-021 Vector base SHALL be 16'hFFFA for NMI, 16'hFFFE for IRQ and 16'hFFFC for reset.
REQ-022 VEC_LO SHALL drive addr=base and latch data_in into vec_lo.
REQ-023 VEC_HI SHALL drive addr=base+1, latch data_in into vec_hi and assert set_i=1.
REQ-024 LOAD SHALL assert pc_load=1 with pc_addr={vec_hi,vec_lo}, then go to IDLE; we=0 and sp_dec=0 in all states other than PUSH_*.
REQ-025 busy SHALL be 1 in every state except IDLE; IRQ service SHALL take exactly 6 cycles from leaving IDLE to the return to IDLE.
REQ-026 RST_LO/RST_HI SHALL read FFFC/FFFD into vec_lo/vec_hi with no writes, no sp_dec and set_i=1 in RST_HI, then go to LOAD.
REQ-027 In idle cycles addr SHALL equal pc_in, data_out SHALL be 0 and pc_addr SHALL be 0.

Reset
REQ-028 While rst=1, SHALL force state=RST_LO, nmi_pend=0, nmi sample=1, kind=RESET, vec_lo=vec_hi=0, we=0, pc_load=0, sp_dec=0, set_i=0, busy=1, addr=16'hFFFC.
REQ-029 rst asserted mid-sequence SHALL abort on the next edge with no further write or pc_load.
REQ-030 The first cycle after rst deasserts SHALL be RST_LO.

Verification
REQ-031 Reset vector: mem[FFFC]=34, mem[FFFD]=12, release rst -> pc_load=1 with pc_addr=1234 on the 3rd cycle, then busy=0.
REQ-032 IRQ: pc_in=C005, sp_in=FF then FE then FD, p_in=30, irq_n=0, i_flag=0, insn_done pulse -> writes 0x01FF=C0, 0x01FE=05, 0x01FD=20; reads FFFE/FFFF; pc_load to vector; set_i pulses once.
REQ-033 Masked IRQ: i_flag=1, irq_n=0, repeated insn_done -> busy stays 0 and we never asserts.
REQ-034 NMI edge then low hold: one falling edge with nmi_n held low for 20 cycles and 3 insn_done pulses -> exactly one NMI sequence, vector FFFA/FFFB.
REQ-035 Hijack: IRQ service entered, nmi_n falls during PUSH_L -> vector read from FFFA, nmi_pend=0 afterwards, no second NMI sequence.
REQ-036 Reset mid-sequence: assert rst during PUSH_L -> we=0 on the next cycle, then the reset-vector sequence completes normally.

Source files
------------

// File: rtl/mos6502s_interrupt_sequencer.sv
// mos6502s_interrupt_sequencer
// Sequences 6502-style reset, NMI and IRQ entry. It pushes PCH, PCL and P
// onto the stack, fetches the vector, and loads the PC. While a sequence is
// running, busy stalls the core.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   nmi_n, irq_n        NMI (falling-edge) and IRQ (level) requests, active-low
//   i_flag, insn_done   interrupt-disable flag, instruction-boundary pulse
//   pc_in, sp_in, p_in  current PC, stack pointer, status register
//   data_in             read data for the address driven this cycle
//   addr, data_out, we  memory bus
//   pc_load, pc_addr    program-counter load strobe and value
//   sp_dec, set_i, busy SP decrement, I-flag set, sequence active
module mos6502s_interrupt_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        nmi_n,
  input  logic        irq_n,
  input  logic        i_flag,
  input  logic        insn_done,
  input  logic [15:0] pc_in,
  input  logic [7:0]  sp_in,
  input  logic [7:0]  p_in,
  input  logic [7:0]  data_in,
  output logic [15:0] addr,
  output logic [7:0]  data_out,
  output logic        we,
  output logic        pc_load,
  output logic [15:0] pc_addr,
  output logic        sp_dec,
  output logic        set_i,
  output logic        busy
);

  typedef enum logic [3:0] {
    RST_LO, RST_HI, IDLE, PUSH_H, PUSH_L, PUSH_P, VEC_LO, VEC_HI, LOAD
  } state_t;

  typedef enum logic [1:0] {K_RESET, K_NMI, K_IRQ} kind_t;

  state_t      state_q, state_d;
  kind_t       kind_q, kind_d;
  logic        nmi_s_q, nmi_s_d;
  logic        nmi_pend_q, nmi_pend_d;
  logic [7:0]  vec_lo_q, vec_lo_d;
  logic [7:0]  vec_hi_q, vec_hi_d;

  logic        nmi_edge;
  logic        nmi_clr;
  logic [15:0] vec_base;

  assign nmi_edge = nmi_s_q & ~nmi_n;

  always_comb begin
    state_d  = state_q;
    kind_d   = kind_q;
    vec_lo_d = vec_lo_q;
    vec_hi_d = vec_hi_q;
    nmi_s_d  = nmi_n;
    nmi_clr  = 1'b0;
    case (state_q)
      RST_LO: begin
        vec_lo_d = data_in;
        state_d  = RST_HI;
      end
      RST_HI: begin
        vec_hi_d = data_in;
        state_d  = LOAD;
      end
      IDLE: begin
        if (insn_done) begin
          if (nmi_pend_q) begin
            state_d = PUSH_H;
            kind_d  = K_NMI;
            nmi_clr = 1'b1;
          end else if (!irq_n && !i_flag) begin
            state_d = PUSH_H;
            kind_d  = K_IRQ;
          end
        end
      end
      PUSH_H, PUSH_L, PUSH_P: begin
        // A pending NMI arriving during IRQ pushes takes over the vector.
        if (kind_q == K_IRQ && nmi_pend_q) begin
          kind_d  = K_NMI;
          nmi_clr = 1'b1;
        end
        state_d = (state_q == PUSH_H) ? PUSH_L :
                  (state_q == PUSH_L) ? PUSH_P : VEC_LO;
      end
      VEC_LO: begin
        vec_lo_d = data_in;
        state_d  = VEC_HI;
      end
      VEC_HI: begin
        vec_hi_d = data_in;
        state_d  = LOAD;
      end
      LOAD:    state_d = IDLE;
      default: state_d = RST_LO;
    endcase
    // A new edge in the same cycle as a clear keeps the request pending.
    nmi_pend_d = nmi_edge | (nmi_pend_q & ~nmi_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RST_LO;
      kind_q     <= K_RESET;
      nmi_s_q    <= 1'b1;
      nmi_pend_q <= 1'b0;
      vec_lo_q   <= '0;
      vec_hi_q   <= '0;
    end else begin
      state_q    <= state_d;
      kind_q     <= kind_d;
      nmi_s_q    <= nmi_s_d;
      nmi_pend_q <= nmi_pend_d;
      vec_lo_q   <= vec_lo_d;
      vec_hi_q   <= vec_hi_d;
    end
  end

  always_comb begin
    case (kind_q)
      K_NMI:   vec_base = 16'hFFFA;
      K_IRQ:   vec_base = 16'hFFFE;
      default: vec_base = 16'hFFFC;
    endcase
  end

  // Bus outputs are decoded from the state register, not registered again.
  // Stack addresses and read data must line up with the same-cycle sp_in
  // and data_in. rst overrides them so the bus goes quiet immediately.
  always_comb begin
    addr     = pc_in;
    data_out = '0;
    we       = 1'b0;
    sp_dec   = 1'b0;
    set_i    = 1'b0;
    pc_load  = 1'b0;
    pc_addr  = '0;
    busy     = (state_q != IDLE);
    case (state_q)
      RST_LO: addr = 16'hFFFC;
      RST_HI: begin
        addr  = 16'hFFFD;
        set_i = 1'b1;
      end
      PUSH_H, PUSH_L, PUSH_P: begin
        addr   = {8'h01, sp_in};
        we     = 1'b1;
        sp_dec = 1'b1;
        case (state_q)
          PUSH_H:  data_out = pc_in[15:8];
          PUSH_L:  data_out = pc_in[7:0];
          default: data_out = {p_in[7:6], 1'b1, 1'b0, p_in[3:0]};
        endcase
      end
      VEC_LO: addr = vec_base;
      VEC_HI: begin
        addr  = vec_base + 16'd1;
        set_i = 1'b1;
      end
      LOAD: begin
        pc_load = 1'b1;
        pc_addr = {vec_hi_q, vec_lo_q};
      end
      default: ;
    endcase
    if (rst) begin
      addr     = 16'hFFFC;
      data_out = '0;
      we       = 1'b0;
      sp_dec   = 1'b0;
      set_i    = 1'b0;
      pc_load  = 1'b0;
      pc_addr  = '0;
      busy     = 1'b1;
    end
  end

endmodule

// File: tb/tb_mos6502s_interrupt_sequencer.sv
// Testbench for mos6502s_interrupt_sequencer: directed vector table plus
// hand-written sequences for masked IRQ, NMI edge, hijack and mid-reset.
module tb_mos6502s_interrupt_sequencer;

  logic        clk = 1'b0;
  logic        rst, nmi_n, irq_n, i_flag, insn_done;
  logic [15:0] pc_in;
  logic [7:0]  sp_in, p_in, data_in;
  logic [15:0] addr, pc_addr;
  logic [7:0]  data_out;
  logic        we, pc_load, sp_dec, set_i, busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mos6502s_interrupt_sequencer dut (
    .clk(clk), .rst(rst), .nmi_n(nmi_n), .irq_n(irq_n), .i_flag(i_flag),
    .insn_done(insn_done), .pc_in(pc_in), .sp_in(sp_in), .p_in(p_in),
    .data_in(data_in), .addr(addr), .data_out(data_out), .we(we),
    .pc_load(pc_load), .pc_addr(pc_addr), .sp_dec(sp_dec), .set_i(set_i),
    .busy(busy)
  );

  // Vector ROM
  always_comb begin
    case (addr)
      16'hFFFA: data_in = 8'hBC;
      16'hFFFB: data_in = 8'h9A;
      16'hFFFC: data_in = 8'h34;
      16'hFFFD: data_in = 8'h12;
      16'hFFFE: data_in = 8'h78;
      16'hFFFF: data_in = 8'h56;
      default:  data_in = 8'h00;
    endcase
  end

  typedef struct {
    logic        rst, nmi_n, irq_n, i_flag, insn_done;
    logic        busy, we, sp_dec, set_i, pc_load;
    logic [15:0] addr;
    logic [7:0]  dout;
    logic [15:0] pca;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(input logic r, input logic nn, input logic in,
                              input logic fi, input logic id, input logic b,
                              input logic w, input logic sd, input logic si,
                              input logic pl, input logic [15:0] a,
                              input logic [7:0] d, input logic [15:0] pa);
    vec_t v;
    v.rst = r; v.nmi_n = nn; v.irq_n = in; v.i_flag = fi; v.insn_done = id;
    v.busy = b; v.we = w; v.sp_dec = sd; v.set_i = si; v.pc_load = pl;
    v.addr = a; v.dout = d; v.pca = pa;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Advance one clock; mimic the core decrementing SP after a push.
  task automatic adv();
    logic d;
    d = sp_dec;
    @(posedge clk);
    #1;
    if (d) sp_in = sp_in - 8'd1;
  endtask

  int wc, pl, rfa, rfe, bc;
  logic [15:0] pa_seen;

  task automatic sample_and_adv();
    #3;
    if (we) wc++;
    if (busy) bc++;
    if (pc_load) begin
      pl++;
      pa_seen = pc_addr;
    end
    if (busy && addr == 16'hFFFA) rfa++;
    if (busy && addr == 16'hFFFE) rfe++;
    adv();
  endtask

  task automatic clr_counts();
    wc = 0; pl = 0; rfa = 0; rfe = 0; bc = 0; pa_seen = '0;
  endtask

  initial begin
    rst = 1'b1; nmi_n = 1'b1; irq_n = 1'b1; i_flag = 1'b0; insn_done = 1'b0;
    pc_in = 16'hC005; sp_in = 8'hFF; p_in = 8'h30;

    //        rst nmi irq  I  id  busy we sd si pl  addr      dout   pca
    tbl[0]  = mk(1, 1, 1, 0, 0,  1, 0, 0, 0, 0, 16'hFFFC, 8'h00, 16'h0000);
    tbl[1]  = mk(1, 1, 1, 0, 0,  1, 0, 0, 0, 0, 16'hFFFC, 8'h00, 16'h0000);
    tbl[2]  = mk(0, 1, 1, 0, 0,  1, 0, 0, 0, 0, 16'hFFFC, 8'h00, 16'h0000);
    tbl[3]  = mk(0, 1, 1, 0, 0,  1, 0, 0, 1, 0, 16'hFFFD, 8'h00, 16'h0000);
    tbl[4]  = mk(0, 1, 1, 0, 0,  1, 0, 0, 0, 1, 16'hC005, 8'h00, 16'h1234);
    tbl[5]  = mk(0, 1, 1, 0, 1,  0, 0, 0, 0, 0, 16'hC005, 8'h00, 16'h0000);
    tbl[6]  = mk(0, 1, 0, 1, 1,  0, 0, 0, 0, 0, 16'hC005, 8'h00, 16'h0000);
    tbl[7]  = mk(0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 16'hC005, 8'h00, 16'h0000);
    tbl[8]  = mk(0, 1, 0, 0, 1,  0, 0, 0, 0, 0, 16'hC005, 8'h00, 16'h0000);
    tbl[9]  = mk(0, 1, 1, 0, 0,  1, 1, 1, 0, 0, 16'h01FF, 8'hC0, 16'h0000);
    tbl[10] = mk(0, 1, 1, 0, 0,  1, 1, 1, 0, 0, 16'h01FE, 8'h05, 16'h0000);
    tbl[11] = mk(0, 1, 1, 0, 0,  1, 1, 1, 0, 0, 16'h01FD, 8'h20, 16'h0000);
    tbl[12] = mk(0, 1, 1, 0, 0,  1, 0, 0, 0, 0, 16'hFFFE, 8'h00, 16'h0000);
    tbl[13] = mk(0, 1, 1, 0, 0,  1, 0, 0, 1, 0, 16'hFFFF, 8'h00, 16'h0000);
    tbl[14] = mk(0, 1, 1, 0, 0,  1, 0, 0, 0, 1, 16'hC005, 8'h00, 16'h5678);
    tbl[15] = mk(0, 1, 1, 0, 0,  0, 0, 0, 0, 0, 16'hC005, 8'h00, 16'h0000);

    for (int i = 0; i < 16; i++) begin
      rst = tbl[i].rst; nmi_n = tbl[i].nmi_n; irq_n = tbl[i].irq_n;
      i_flag = tbl[i].i_flag; insn_done = tbl[i].insn_done;
      #3;
      chk($sformatf("vec%0d", i),
          {19'd0, busy, we, sp_dec, set_i, pc_load, addr, data_out, pc_addr},
          {19'd0, tbl[i].busy, tbl[i].we, tbl[i].sp_dec, tbl[i].set_i,
           tbl[i].pc_load, tbl[i].addr, tbl[i].dout, tbl[i].pca});
      adv();
    end

    // Masked IRQ with repeated instruction boundaries
    clr_counts();
    i_flag = 1'b1; irq_n = 1'b0;
    for (int i = 0; i < 12; i++) begin
      insn_done = (i % 2 == 0);
      sample_and_adv();
    end
    chk("masked_busy", bc, 0);
    chk("masked_we", wc, 0);

    // NMI single edge, held low across several boundaries
    clr_counts();
    sp_in = 8'hFF; irq_n = 1'b1; i_flag = 1'b1;
    for (int i = 0; i < 30; i++) begin
      nmi_n = (i >= 1 && i < 21) ? 1'b0 : 1'b1;
      insn_done = (i == 3 || i == 11 || i == 17);
      sample_and_adv();
    end
    chk("nmi_writes", wc, 3);
    chk("nmi_loads", pl, 1);
    chk("nmi_vec_read", rfa, 1);
    chk("nmi_pc_addr", pa_seen, 16'h9ABC);

    // IRQ hijacked by NMI falling during PUSH_L
    clr_counts();
    sp_in = 8'hFF; i_flag = 1'b0;
    for (int i = 0; i < 30; i++) begin
      irq_n = (i == 0) ? 1'b0 : 1'b1;
      insn_done = (i == 0 || i == 12 || i == 16);
      nmi_n = (i >= 2 && i < 6) ? 1'b0 : 1'b1;
      sample_and_adv();
    end
    chk("hij_writes", wc, 3);
    chk("hij_loads", pl, 1);
    chk("hij_nmi_vec", rfa, 1);
    chk("hij_irq_vec", rfe, 0);
    chk("hij_pc_addr", pa_seen, 16'h9ABC);

    // Reset during PUSH_L
    sp_in = 8'hFF; nmi_n = 1'b1; irq_n = 1'b0; i_flag = 1'b0; insn_done = 1'b1;
    #3; adv();                          // IDLE, request accepted
    irq_n = 1'b1; insn_done = 1'b0;
    #3; chk("mr_push_h_we", we, 1'b1);
    adv();
    rst = 1'b1;                         // PUSH_L with reset asserted
    #3; chk("mr_rst_cycle", {busy, we, addr}, {1'b1, 1'b0, 16'hFFFC});
    adv();
    rst = 1'b0;
    #3; chk("mr_rst_lo", {busy, we, sp_dec, addr}, {1'b1, 1'b0, 1'b0, 16'hFFFC});
    adv();
    #3; chk("mr_rst_hi", {we, set_i, addr}, {1'b0, 1'b1, 16'hFFFD});
    adv();
    #3; chk("mr_load", {pc_load, pc_addr}, {1'b1, 16'h1234});
    adv();
    #3; chk("mr_idle", {busy, pc_load}, {1'b0, 1'b0});
    adv();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
